// File: rtl/psec_sca_ctrl.sv
// Sampling controller for one PSEC channel: bank write enables, sample/trigger
// counting, post-trigger stop delay and serial readout of the captured counters.
module psec_sca_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = 12,
  parameter int TRIG_W    = 8,
  parameter int DLY_W     = 8,
  parameter int BSEL_W    = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_req,
  input  logic                 start,
  input  logic [1:0]           smode,
  input  logic [BSEL_W-1:0]    bank_sel,
  input  logic                 slow_sel,
  input  logic                 trigger,
  input  logic [DLY_W-1:0]     stop_dly,
  input  logic                 readout_req,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 slow_en,
  output logic                 sdo,
  output logic                 sdo_valid,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int SR_W  = TRIG_W + CNT_W + 4;
  localparam int BIT_W = $clog2(SR_W);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_STOPPED  = 3'd1;
  localparam logic [2:0] ST_SAMPLING = 3'd2;
  localparam logic [2:0] ST_STOPPING = 3'd3;
  localparam logic [2:0] ST_READOUT  = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [TRIG_W-1:0] trig_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [BSEL_W-1:0] grp;
  logic [SR_W-1:0]   sr;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SR_W-1:0]   sr_load;

  function automatic logic [NUM_BANKS-1:0] bank_mask(input logic [1:0] mode,
                                                     input logic [BSEL_W-1:0] sel);
    logic [NUM_BANKS-1:0] m;
    m = '0;
    case (mode)
      2'b00:   m = NUM_BANKS'(1) << sel;
      2'b01:   m = NUM_BANKS'(3) << (sel & ~BSEL_W'(1));
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [TRIG_W-1:0] sat_inc(input logic [TRIG_W-1:0] v);
    return (v == '1) ? v : v + TRIG_W'(1);
  endfunction

  // grp is zero-extended to a fixed 4-bit field so the frame layout is bank-count independent
  assign sr_load = {trig_cnt, cnt, 4'(grp)};
  assign busy    = (state == ST_SAMPLING) || (state == ST_STOPPING) || (state == ST_READOUT);

  always_ff @(posedge clk) begin
    if (rst || init_req) begin
      state     <= ST_INIT;
      cnt       <= '0;
      trig_cnt  <= '0;
      dly_cnt   <= '0;
      grp       <= '0;
      bit_cnt   <= '0;
      bank_en   <= '0;
      slow_en   <= 1'b0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        ST_INIT, ST_STOPPED: begin
          if (start) begin
            if (smode == 2'b10 && !slow_sel) begin
              cfg_err <= 1'b1;
            end else begin
              state <= ST_SAMPLING;
              if (slow_sel) begin
                slow_en <= 1'b1;
                bank_en <= '0;
                grp     <= '0;
              end else begin
                bank_en <= bank_mask(smode, bank_sel);
                grp     <= (smode == 2'b11) ? '0 : bank_sel;
              end
            end
          end else if (state == ST_STOPPED && readout_req) begin
            state     <= ST_READOUT;
            sdo       <= sr_load[SR_W-1];
            sdo_valid <= 1'b1;
            bit_cnt   <= BIT_W'(SR_W - 1);
          end
        end
        ST_SAMPLING: begin
          cnt <= cnt + CNT_W'(1);
          if (trigger) begin
            trig_cnt <= sat_inc(trig_cnt);
            if (stop_dly == '0) begin
              state   <= ST_STOPPED;
              bank_en <= '0;
              slow_en <= 1'b0;
            end else begin
              dly_cnt <= stop_dly;
              state   <= ST_STOPPING;
            end
          end
        end
        ST_STOPPING: begin
          cnt     <= cnt + CNT_W'(1);
          dly_cnt <= dly_cnt - DLY_W'(1);
          if (trigger) trig_cnt <= sat_inc(trig_cnt);
          if (dly_cnt == DLY_W'(1)) begin
            state   <= ST_STOPPED;
            bank_en <= '0;
            slow_en <= 1'b0;
          end
        end
        ST_READOUT: begin
          if (bit_cnt == '0) begin
            state     <= ST_STOPPED;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
          end else begin
            sdo     <= sr[SR_W-1];
            bit_cnt <= bit_cnt - BIT_W'(1);
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Shift data path carries no reset; it is fully reloaded on every readout request
  always_ff @(posedge clk) begin
    if (state == ST_STOPPED && !start && readout_req) sr <= sr_load << 1;
    else if (state == ST_READOUT)                      sr <= sr << 1;
  end

endmodule

// File: tb/tb_psec_sca_ctrl.sv
// Directed bench for psec_sca_ctrl: enables, stop delay, saturation, readout frames,
// configuration error and init priority.
module tb_psec_sca_ctrl;

  logic       clk = 1'b0;
  logic       rst, init_req, start, slow_sel, trigger, readout_req;
  logic [1:0] smode;
  logic [1:0] bank_sel;
  logic [7:0] stop_dly;
  logic [3:0] bank_en;
  logic       slow_en, sdo, sdo_valid, busy, cfg_err;

  int errors = 0;
  int checks = 0;

  psec_sca_ctrl #(.NUM_BANKS(4), .CNT_W(12), .TRIG_W(8), .DLY_W(8)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .start(start), .smode(smode),
    .bank_sel(bank_sel), .slow_sel(slow_sel), .trigger(trigger), .stop_dly(stop_dly),
    .readout_req(readout_req), .bank_en(bank_en), .slow_en(slow_en), .sdo(sdo),
    .sdo_valid(sdo_valid), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] sel, input logic slow,
                          input logic [7:0] dly);
    smode = m; bank_sel = sel; slow_sel = slow; stop_dly = dly; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_now();
    stop_dly = 8'd0; trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic do_readout(input string tag, input logic [23:0] exp);
    readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      chk({tag, "_bit"}, 32'({busy, sdo_valid, sdo}), 32'({1'b1, 1'b1, exp[i]}));
      tick();
    end
    chk({tag, "_end"}, 32'({busy, sdo_valid, sdo}), 32'h0);
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; start = 1'b0; slow_sel = 1'b0; trigger = 1'b0;
    readout_req = 1'b0; smode = 2'b00; bank_sel = 2'd0; stop_dly = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_outputs", 32'({bank_en, slow_en, sdo, sdo_valid, busy, cfg_err}), 32'h0);

    // single bank, ignored start and readout while sampling, immediate stop
    do_start(2'b00, 2'd2, 1'b0, 8'd0);
    chk("single_bank_en", 32'(bank_en), 32'h4);
    chk("single_busy", 32'(busy), 32'h1);
    do_start(2'b11, 2'd0, 1'b0, 8'd0);
    chk("start_ignored", 32'(bank_en), 32'h4);
    readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    chk("ro_ignored_sampling", 32'({sdo_valid, busy}), 32'h1);
    stop_now();
    chk("dly0_stop", 32'({bank_en, busy}), 32'h0);

    do_start(2'b01, 2'd3, 1'b0, 8'd0);
    chk("pair_bank_en", 32'(bank_en), 32'hC);
    stop_now();
    do_start(2'b11, 2'd1, 1'b0, 8'd0);
    chk("all_bank_en", 32'(bank_en), 32'hF);
    stop_now();
    do_start(2'b00, 2'd1, 1'b1, 8'd0);
    chk("slow_en", 32'({slow_en, bank_en}), 32'h10);
    stop_now();
    chk("slow_stop", 32'({slow_en, busy}), 32'h0);

    // clean counters, then stop_dly=5 window with two retriggers; cnt ends at 165
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    do_start(2'b00, 2'd2, 1'b0, 8'd5);
    repeat (159) tick();
    chk("pre_trig_busy", 32'({busy, bank_en}), 32'h14);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("stopping_s1", 32'(bank_en), 32'h4);
    tick();
    chk("stopping_s2", 32'(bank_en), 32'h4);
    trigger = 1'b1;
    tick();
    chk("stopping_s3", 32'(bank_en), 32'h4);
    tick();
    trigger = 1'b0;
    chk("stopping_s4", 32'(bank_en), 32'h4);
    tick();
    chk("stopping_s5", 32'({busy, bank_en}), 32'h14);
    tick();
    chk("stopped_after_dly", 32'({busy, bank_en}), 32'h0);
    do_readout("ro_a5", 24'h030A52);
    do_readout("ro_repeat", 24'h030A52);

    // trigger saturation across two sessions: 256 + 44 triggers, cnt = 300
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    do_start(2'b11, 2'd2, 1'b0, 8'd255);
    chk("sat_all_en", 32'(bank_en), 32'hF);
    trigger = 1'b1;
    repeat (255) tick();
    chk("sat_still_busy", 32'(busy), 32'h1);
    tick();
    trigger = 1'b0;
    chk("sat_stopped", 32'({busy, bank_en}), 32'h0);
    do_start(2'b11, 2'd0, 1'b0, 8'd43);
    trigger = 1'b1;
    repeat (43) tick();
    chk("sat2_busy", 32'(busy), 32'h1);
    tick();
    trigger = 1'b0;
    chk("sat2_stopped", 32'(busy), 32'h0);
    do_readout("ro_sat", 24'hFF12C0);

    // reserved mode flags cfg_err without leaving STOPPED; slow_sel overrides it
    do_start(2'b10, 2'd1, 1'b0, 8'd0);
    chk("cfg_err_set", 32'({cfg_err, busy, bank_en}), 32'h20);
    do_start(2'b10, 2'd1, 1'b1, 8'd0);
    chk("cfg_err_slow_ok", 32'({cfg_err, slow_en, busy}), 32'h7);
    stop_now();
    readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    tick(); tick();
    chk("mid_readout", 32'({sdo_valid, busy}), 32'h3);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    chk("init_mid_readout", 32'({bank_en, slow_en, sdo, sdo_valid, busy, cfg_err}), 32'h0);
    readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    chk("ro_ignored_init", 32'({sdo_valid, busy}), 32'h0);
    do_start(2'b00, 2'd1, 1'b0, 8'd0);
    stop_now();
    do_readout("ro_after_init", 24'h010011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psec_sca_ctrl.md
Name: psec_sca_ctrl

Overview:
Per-channel sampling controller for a generalised PSEC channel with NUM_BANKS fast SCA banks plus one slow bank. It selects which banks write, counts sample clocks and triggers, stops a programmable delay after the first trigger, and shifts the counter and trigger data out serially. It replaces the fixed four-bank state set with parametrised bank grouping, post-trigger stop delay and a built-in readout shifter.

Parameters:
NUM_BANKS, 4, number of fast banks; power of 2, 2..16
CNT_W, 12, width of the sample-clock counter
TRIG_W, 8, width of the saturating trigger counter
DLY_W, 8, width of the stop-delay value
BSEL_W, $clog2(NUM_BANKS), width of bank_sel

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
init_req  in  1  pulse: clear counters, go to INIT
start  in  1  pulse: begin sampling with the current mode/bank_sel/slow_sel
smode  in  2  00 = one bank, 01 = aligned pair, 11 = all fast banks, 10 = reserved
bank_sel  in  BSEL_W  bank index; in pair mode the LSB is ignored
slow_sel  in  1  when set, sample the slow bank only; smode and bank_sel are ignored
trigger  in  1  trigger pulse, one cycle
stop_dly  in  DLY_W  cycles from the first trigger to stop
readout_req  in  1  pulse: serialise data (honoured only in STOPPED)
bank_en  out  NUM_BANKS  write-strobe enable per fast bank
slow_en  out  1  slow-bank enable
sdo  out  1  serial data, MSB first
sdo_valid  out  1  high while sdo carries data
busy  out  1  high in SAMPLING, STOPPING and READOUT
cfg_err  out  1  sticky flag: start was issued with smode = 10

Behaviour:
- States: INIT, STOPPED, SAMPLING, STOPPING, READOUT. The state register and all outputs update on the rising edge of clk.
- Reset, or init_req in any state:
  - next state is INIT; cnt = 0, trig_cnt = 0, dly_cnt = 0, grp = 0.
  - bank_en = 0, slow_en = 0, sdo = 0, sdo_valid = 0, busy = 0, cfg_err = 0.
  - init_req has priority over every other input.
- INIT or STOPPED + start:
  - If smode = 10 and slow_sel = 0: set cfg_err, stay in the current state.
  - Otherwise latch the configuration and enter SAMPLING. bank_en/slow_en are asserted from the next cycle.
  - start does not clear cnt or trig_cnt; only INIT clears them.
- Bank enables in SAMPLING and STOPPING:
  - slow_sel: slow_en = 1, bank_en = 0.
  - 00: bank_en = one-hot(bank_sel).
  - 01: bank_en = 2'b11 << (2*(bank_sel>>1)).
  - 11: bank_en = all ones.
  - grp records the latched bank_sel, or 0 when smode = 11 or slow_sel = 1.
- cnt increments by 1 every cycle in SAMPLING and STOPPING, wrapping from 2^CNT_W-1 to 0. It holds in all other states.
- trigger in SAMPLING or STOPPING increments trig_cnt, saturating at 2^TRIG_W-1. Triggers in other states are ignored.
- First trigger in SAMPLING:
  - If stop_dly = 0: go directly to STOPPED next cycle; enables drop on that edge.
  - Otherwise: load dly_cnt = stop_dly and enter STOPPING.
- STOPPING: dly_cnt decrements each cycle. When dly_cnt = 1, the next state is STOPPED and enables drop. Enables stay high for exactly stop_dly cycles after the trigger cycle.
- Retriggers during STOPPING increment trig_cnt but do not reload dly_cnt.
- start during SAMPLING, STOPPING or READOUT is ignored.
- STOPPED + readout_req:
  - Load the shift register with {trig_cnt, cnt, grp padded to 4 bits}, total SR = TRIG_W + CNT_W + 4 bits.
  - Enter READOUT. sdo_valid is high for exactly SR cycles, starting the cycle after the request, with sdo carrying MSB first.
  - After the last bit, return to STOPPED with sdo_valid = 0 and sdo = 0.
- readout_req in any state other than STOPPED is ignored. Readout does not alter cnt or trig_cnt.
- busy = 1 exactly when the state is SAMPLING, STOPPING or READOUT.
- cfg_err clears only on rst or init_req.

Test Plan:
- rst, then start with smode = 00, bank_sel = 2 -> bank_en = 0100 from cycle 1; cnt increments each cycle; busy = 1.
- smode = 01, bank_sel = 3 -> bank_en = 1100. smode = 11 -> 1111. slow_sel = 1 -> slow_en = 1, bank_en = 0000.
- stop_dly = 5, trigger at cycle 10, retrigger at cycle 12 -> enables high through cycle 15, low from cycle 16; trig_cnt = 2; STOPPED.
- stop_dly = 0 with a trigger -> STOPPED on the next edge. 300 triggers with TRIG_W = 8 -> trig_cnt = 255.
- Stopped with trig_cnt = 0x03, cnt = 0x0A5, grp = 2, then readout_req -> 24 valid bits 0x030A52 MSB first, then back to STOPPED. A readout_req during SAMPLING is ignored.
- start with smode = 10 -> cfg_err = 1, state unchanged. init_req mid-READOUT -> INIT next cycle, sdo_valid = 0, counters 0, cfg_err = 0.
